// File: rtl/oled_text_sequencer.sv
// Text sequencer for an 8x8-font OLED: buffers received bytes, interprets
// printable characters and control codes, and issues CHAR / CURSOR / CLEAR
// commands to the display driver over a valid/ready handshake.
module oled_text_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned COLS       = 16,
    parameter int unsigned PAGES      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 char_in,
    input  logic                       char_valid,
    output logic [1:0]                 cmd_op,
    output logic [7:0]                 cmd_data,
    output logic [$clog2(COLS)-1:0]    cmd_col,
    output logic [$clog2(PAGES)-1:0]   cmd_page,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(PAGES);

    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_MAX  = PW'(PAGES - 1);

    localparam logic [1:0] OP_CHAR   = 2'b00;
    localparam logic [1:0] OP_CURSOR = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StIssueClear,
        StIssueChar,
        StIssueCursor
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_t        state;
    logic [7:0]    hold;
    logic [CW-1:0] col;
    logic [PW-1:0] page;

    // Page advance wraps at PAGES, which need not be a power of two.
    function automatic logic [PW-1:0] next_page(input logic [PW-1:0] p);
        return (p == PAGE_MAX) ? '0 : p + 1'b1;
    endfunction

    // FIFO handshake decode; a full FIFO drops the byte even if a pop happens now.
    always_comb begin
        push = char_valid && (count < FIFO_FULL);
        pop  = (state == StIdle) && (count != '0);
        busy = (count != '0) || (state != StIdle);
    end

    // Character storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= char_in;
        end
    end

    // FIFO pointers, occupancy and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= char_valid && (count == FIFO_FULL);
        end
    end

    // Command sequencer with registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            hold      <= '0;
            col       <= '0;
            page      <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_CHAR;
            cmd_data  <= '0;
            cmd_col   <= '0;
            cmd_page  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        hold  <= mem[rd_ptr];
                        state <= StDecode;
                    end
                end

                StDecode: begin
                    if (hold >= 8'h20 && hold <= 8'h7E) begin
                        cmd_op    <= OP_CHAR;
                        cmd_data  <= hold;
                        cmd_col   <= col;
                        cmd_page  <= page;
                        cmd_valid <= 1'b1;
                        state     <= StIssueChar;
                    end else begin
                        case (hold)
                            8'h0D: begin
                                col       <= '0;
                                cmd_op    <= OP_CURSOR;
                                cmd_data  <= '0;
                                cmd_col   <= '0;
                                cmd_page  <= page;
                                cmd_valid <= 1'b1;
                                state     <= StIssueCursor;
                            end
                            8'h0A: begin
                                page      <= next_page(page);
                                cmd_op    <= OP_CURSOR;
                                cmd_data  <= '0;
                                cmd_col   <= col;
                                cmd_page  <= next_page(page);
                                cmd_valid <= 1'b1;
                                state     <= StIssueCursor;
                            end
                            8'h08: begin
                                col       <= (col == '0) ? '0 : col - 1'b1;
                                cmd_op    <= OP_CURSOR;
                                cmd_data  <= '0;
                                cmd_col   <= (col == '0) ? '0 : col - 1'b1;
                                cmd_page  <= page;
                                cmd_valid <= 1'b1;
                                state     <= StIssueCursor;
                            end
                            8'h0C: begin
                                col       <= '0;
                                page      <= '0;
                                cmd_op    <= OP_CLEAR;
                                cmd_data  <= '0;
                                cmd_col   <= '0;
                                cmd_page  <= '0;
                                cmd_valid <= 1'b1;
                                state     <= StIssueClear;
                            end
                            default: state <= StIdle;
                        endcase
                    end
                end

                StIssueClear: begin
                    // After clearing, home the cursor explicitly.
                    if (cmd_ready) begin
                        cmd_op   <= OP_CURSOR;
                        cmd_data <= '0;
                        cmd_col  <= '0;
                        cmd_page <= '0;
                        state    <= StIssueCursor;
                    end
                end

                StIssueChar: begin
                    if (cmd_ready) begin
                        if (col != COL_MAX) begin
                            // Driver auto-advances its column; no cursor needed.
                            col       <= col + 1'b1;
                            cmd_valid <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            col      <= '0;
                            page     <= next_page(page);
                            cmd_op   <= OP_CURSOR;
                            cmd_data <= '0;
                            cmd_col  <= '0;
                            cmd_page <= next_page(page);
                            state    <= StIssueCursor;
                        end
                    end
                end

                StIssueCursor: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/oled_text_sequencer.md
OLED_TEXT_SEQUENCER -- requirements
Module: oled_text_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning the received-character buffer depth (power of two, >=4).
REQ-002 SHALL have parameter COLS, default 16, meaning character columns per page (8x8 font on a 128-pixel-wide display).
REQ-003 SHALL have parameter PAGES, default 8, meaning display pages (rows).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port char_in  input  8  received byte from the UART receiver.
REQ-007 SHALL have port char_valid  input  1  one-cycle strobe qualifying char_in.
REQ-008 SHALL have port cmd_op  output  2  command to the display driver: 00 CHAR, 01 CURSOR, 10 CLEAR.
REQ-009 SHALL have port cmd_data  output  8  glyph code for CHAR, otherwise 0.
REQ-010 SHALL have port cmd_col  output  $clog2(COLS)  target column.
REQ-011 SHALL have port cmd_page  output  $clog2(PAGES)  target page.
REQ-012 SHALL have port cmd_valid  output  1  command fields valid.
REQ-013 SHALL have port cmd_ready  input  1  driver accepts the command.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when a byte is dropped.
REQ-015 SHALL have port busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-016 SHALL write char_in into the FIFO on any cycle where char_valid=1 and the registered count < FIFO_DEPTH.
REQ-017 SHALL drop the byte and pulse overflow on the next cycle when char_valid=1 with the FIFO full, even if a pop occurs in the same cycle.
REQ-018 SHALL support a simultaneous push and pop when not full, leaving the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 SHALL implement FSM states IDLE, DECODE, ISSUE_CLEAR, ISSUE_CHAR, ISSUE_CURSOR.
REQ-020 IDLE: when the FIFO is non-empty, SHALL pop one byte into a holding register and go to DECODE.
REQ-021 DECODE, 0x20-0x7E: SHALL go to ISSUE_CHAR with cmd_data set to the byte at the current col/page.
REQ-022 DECODE, 0x0D (CR): SHALL set col=0 and go to ISSUE_CURSOR.
REQ-023 DECODE, 0x0A (LF): SHALL set page=(page+1) mod PAGES, leave col unchanged, and go to ISSUE_CURSOR.
REQ-024 DECODE, 0x08 (BS): SHALL set col=col-1, saturating at 0, and go to ISSUE_CURSOR.
REQ-025 DECODE, 0x0C (FF): SHALL set col=0 and page=0, then go to ISSUE_CLEAR.
REQ-026 DECODE, any other byte: SHALL discard it with no command and return to IDLE.
REQ-027 In each ISSUE_* state, SHALL assert cmd_valid and hold all cmd_* fields stable until the cycle where cmd_ready=1; the transfer occurs on cmd_valid&&cmd_ready.
REQ-028 ISSUE_CLEAR transfer: SHALL go to ISSUE_CURSOR (0,0).
REQ-029 ISSUE_CHAR transfer, col<COLS-1: SHALL set col=col+1 and go to IDLE, with no cursor command (the driver auto-advances).
REQ-030 ISSUE_CHAR transfer, col=COLS-1: SHALL set col=0 and page=(page+1) mod PAGES, then go to ISSUE_CURSOR.
REQ-031 ISSUE_CURSOR transfer: SHALL go to IDLE.
REQ-032 cmd_col/cmd_page in ISSUE_CURSOR SHALL carry the already-updated position.
REQ-033 Latency from a char_valid push into an empty FIFO in IDLE (cycle N) to cmd_valid=1 SHALL be 3 cycles (N+3).
REQ-034 The FSM SHALL pop at most one byte per command sequence; cmd_ready held high gives one command per 3 cycles for printable bytes.
REQ-035 cmd_valid SHALL never depend combinationally on cmd_ready.

Reset
REQ-036 While rst=1, at the clock edge SHALL clear FIFO pointers and count, set col=0, page=0, state=IDLE, and drive cmd_valid=0, cmd_op=0, cmd_data=0, cmd_col=0, cmd_page=0, overflow=0, busy=0.
REQ-037 Reset asserted mid-command SHALL drop cmd_valid on the cycle after the reset edge; a pending command is lost, not replayed.
REQ-038 char_valid during reset SHALL be ignored.

Verification
REQ-039 Bench SHALL cover: "A" (0x41) pushed at cycle N with cmd_ready=1 -> CHAR 0x41 at col0/page0 with cmd_valid at N+3; col becomes 1.
REQ-040 Bench SHALL cover: 16 printable bytes, then 'B' -> 16th CHAR at col15/page0, then CURSOR col0/page1, then CHAR 0x42 at col0/page1.
REQ-041 Bench SHALL cover: cmd_ready held low for 20 cycles while 20 bytes arrive -> 16 or 17 stored (one popped), overflow pulses for each drop, and cmd fields stay stable throughout.
REQ-042 Bench SHALL cover: FF at col5/page3 -> CLEAR, then CURSOR 0/0; BS at col0 -> CURSOR col0; LF at page7 -> CURSOR page0.
REQ-043 Bench SHALL cover: rst pulsed while cmd_valid=1 -> cmd_valid=0 on the next cycle, busy=0, and the next byte is printed at col0/page0.
REQ-044 Bench SHALL cover: byte 0x07 -> no command issued, and the FSM returns to IDLE.
